uart_tx_scheduler: RTL

// Sequences all traffic into the UART transmit FIFO. Arbitrates between periodic player-state

---
 rtl/uart_tx_scheduler_pkg.sv | 34 +++
 rtl/uart_tx_scheduler_tick_gen.sv | 35 +++
 rtl/uart_tx_scheduler.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_scheduler_pkg
// Purpose  : Shared frame constants, FSM state and grant types for the UART
//            transmit scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package uart_tx_scheduler_pkg;

  localparam logic [7:0] UART_HDR_POS  = 8'hA5;
  localparam logic [7:0] UART_HDR_EVT  = 8'h5A;
  localparam int         POS_FRAME_LEN = 7;
  localparam int         EVT_FRAME_LEN = 3;

  typedef enum logic [1:0] {
    TXS_IDLE = 2'd0,
    TXS_SEND = 2'd1,
    TXS_GAP  = 2'd2
  } tx_sched_state_t;

  typedef enum logic {
    GRANT_POS = 1'b0,
    GRANT_EVT = 1'b1
  } tx_grant_t;

  // Status byte of a position frame: selection in [3:2], collisions in [1:0].
  function automatic logic [7:0] pos_status(input logic [1:0] sel,
                                            input logic       p2col,
                                            input logic       p1col);
    return {4'b0000, sel, p2col, p1col};
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_scheduler_tick_gen.sv
`default_nettype none
// ============================================================================
// Module   : tick_gen
// Purpose  : Free-running periodic strobe, one cycle high every TICK_CYCLES
//            clocks (at the terminal count of the internal counter).
// Revision : 1.0 - initial release
// ============================================================================
module tick_gen #(
  parameter int TICK_CYCLES = 1_083_333
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int c_CNT_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [c_CNT_W-1:0] c_TERM = c_CNT_W'(TICK_CYCLES - 1);

  logic [c_CNT_W-1:0] r_cnt;

  assign tick = (r_cnt == c_TERM);

  // Counter wraps to zero after the terminal count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_scheduler
// Purpose  : Arbitrates periodic player-state frames against one-shot event
//            frames and serialises the winner byte-by-byte into the UART TX
//            FIFO under tx_full back-pressure, never interleaving frames.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_scheduler
  import uart_tx_scheduler_pkg::*;
#(
  parameter int TICK_CYCLES = 1_083_333
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [7:0]  current_x_1,
  input  logic [7:0]  current_y_1,
  input  logic [7:0]  current_x_2,
  input  logic [7:0]  current_y_2,
  input  logic        player1_collision,
  input  logic        player2_collision,
  input  logic [1:0]  selected_player,
  input  logic        evt_valid,
  input  logic [7:0]  evt_code,
  output logic        evt_ready,
  input  logic        tx_full,
  output logic        wr_uart,
  output logic [7:0]  w_data,
  output logic        busy,
  output logic [15:0] frames_sent
);

  logic                           w_tick;
  logic                           w_col_rise;
  logic                           w_pos_set;
  logic                           w_pos_req;
  logic                           w_grant_pos;
  logic                           w_grant_evt;
  logic                           w_wr;
  logic                           w_frame_done;
  logic [7:0]                     w_status;
  logic [7:0]                     w_chk;
  tx_sched_state_t                w_state_nxt;

  tx_sched_state_t                r_state;
  tx_grant_t                      r_last_grant;
  logic                           r_pos_pending;
  logic                           r_p1col_d;
  logic                           r_p2col_d;
  logic [POS_FRAME_LEN-1:0][7:0]  r_shift;
  logic [2:0]                     r_idx;
  logic [2:0]                     r_len;
  logic [7:0]                     r_last_data;
  logic                           r_busy;
  logic [15:0]                    r_frames;

  tick_gen #(
    .TICK_CYCLES(TICK_CYCLES)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .tick (w_tick)
  );

  assign w_col_rise = (player1_collision & ~r_p1col_d) | (player2_collision & ~r_p2col_d);
  assign w_pos_set  = enable & (w_tick | w_col_rise);
  assign w_pos_req  = r_pos_pending & enable;
  assign w_status   = pos_status(selected_player, player2_collision, player1_collision);
  assign w_chk      = current_x_1 ^ current_y_1 ^ current_x_2 ^ current_y_2 ^ w_status;

  assign evt_ready   = w_grant_evt;
  assign wr_uart     = w_wr;
  assign w_data      = w_wr ? r_shift[0] : r_last_data;
  assign busy        = r_busy;
  assign frames_sent = r_frames;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= TXS_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state, grant and write-strobe decode; round-robin only on contention.
  always_comb begin
    w_state_nxt  = r_state;
    w_grant_pos  = 1'b0;
    w_grant_evt  = 1'b0;
    w_wr         = 1'b0;
    w_frame_done = 1'b0;
    case (r_state)
      TXS_IDLE: begin
        if (evt_valid && w_pos_req) begin
          if (r_last_grant == GRANT_POS) begin
            w_grant_evt = 1'b1;
          end else begin
            w_grant_pos = 1'b1;
          end
        end else if (evt_valid) begin
          w_grant_evt = 1'b1;
        end else if (w_pos_req) begin
          w_grant_pos = 1'b1;
        end
        if (w_grant_evt || w_grant_pos) begin
          w_state_nxt = TXS_SEND;
        end
      end
      TXS_SEND: begin
        if (!tx_full) begin
          w_wr        = 1'b1;
          w_state_nxt = TXS_GAP;
        end
      end
      TXS_GAP: begin
        if (r_idx == r_len) begin
          w_frame_done = 1'b1;
          w_state_nxt  = TXS_IDLE;
        end else begin
          w_state_nxt = TXS_SEND;
        end
      end
      default: begin
        w_state_nxt = TXS_IDLE;
      end
    endcase
  end

  // Request tracking: collision edge detect, coalescing pending flag, last grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_p1col_d     <= 1'b0;
      r_p2col_d     <= 1'b0;
      r_pos_pending <= 1'b0;
      r_last_grant  <= GRANT_POS;
    end else begin
      r_p1col_d <= player1_collision;
      r_p2col_d <= player2_collision;
      if (!enable) begin
        r_pos_pending <= 1'b0;
      end else if (w_pos_set) begin
        r_pos_pending <= 1'b1;
      end else if (w_grant_pos) begin
        r_pos_pending <= 1'b0;
      end
      if (w_grant_evt) begin
        r_last_grant <= GRANT_EVT;
      end else if (w_grant_pos) begin
        r_last_grant <= GRANT_POS;
      end
    end
  end

  // Frame builder: snapshot payload on grant, shift one byte out per write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_shift     <= '0;
      r_idx       <= '0;
      r_len       <= '0;
      r_last_data <= '0;
    end else begin
      if (w_grant_pos) begin
        r_shift <= {w_chk, w_status, current_y_2, current_x_2,
                    current_y_1, current_x_1, UART_HDR_POS};
        r_len   <= 3'(POS_FRAME_LEN);
        r_idx   <= '0;
      end else if (w_grant_evt) begin
        r_shift <= {8'h00, 8'h00, 8'h00, 8'h00, evt_code, evt_code, UART_HDR_EVT};
        r_len   <= 3'(EVT_FRAME_LEN);
        r_idx   <= '0;
      end else if (w_wr) begin
        r_shift     <= {8'h00, r_shift[POS_FRAME_LEN-1:1]};
        r_idx       <= r_idx + 3'd1;
        r_last_data <= r_shift[0];
      end
    end
  end

  // Status outputs: busy follows the FSM, frame counter wraps naturally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy   <= 1'b0;
      r_frames <= '0;
    end else begin
      r_busy <= (w_state_nxt != TXS_IDLE);
      if (w_frame_done) begin
        r_frames <= r_frames + 16'd1;
      end
    end
  end

endmodule
`default_nettype wire
